// File: rtl/alu_74181_pkg.sv
// ============================================================================
// Module  : alu_74181_pkg
// Brief   : 74181 function-select codes, mode constants and result flag types
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_74181_pkg;

    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    // Logic-mode (M=1) select codes
    localparam logic [3:0] LOG_NOT_A       = 4'd0;
    localparam logic [3:0] LOG_NOR         = 4'd1;
    localparam logic [3:0] LOG_NOTA_AND_B  = 4'd2;
    localparam logic [3:0] LOG_ZERO        = 4'd3;
    localparam logic [3:0] LOG_NAND        = 4'd4;
    localparam logic [3:0] LOG_NOT_B       = 4'd5;
    localparam logic [3:0] LOG_XOR         = 4'd6;
    localparam logic [3:0] LOG_A_AND_NOTB  = 4'd7;
    localparam logic [3:0] LOG_NOTA_OR_B   = 4'd8;
    localparam logic [3:0] LOG_XNOR        = 4'd9;
    localparam logic [3:0] LOG_B           = 4'd10;
    localparam logic [3:0] LOG_AND         = 4'd11;
    localparam logic [3:0] LOG_ONES        = 4'd12;
    localparam logic [3:0] LOG_A_OR_NOTB   = 4'd13;
    localparam logic [3:0] LOG_OR          = 4'd14;
    localparam logic [3:0] LOG_A           = 4'd15;

    // Arithmetic-mode (M=0) select codes; every row also adds cin
    localparam logic [3:0] ARI_A                   = 4'd0;
    localparam logic [3:0] ARI_A_OR_B              = 4'd1;
    localparam logic [3:0] ARI_A_OR_NOTB           = 4'd2;
    localparam logic [3:0] ARI_MINUS1              = 4'd3;
    localparam logic [3:0] ARI_A_PLUS_A_ANDNOTB    = 4'd4;
    localparam logic [3:0] ARI_AORB_PLUS_A_ANDNOTB = 4'd5;
    localparam logic [3:0] ARI_A_PLUS_NOTB         = 4'd6;
    localparam logic [3:0] ARI_A_ANDNOTB_M1        = 4'd7;
    localparam logic [3:0] ARI_A_PLUS_A_AND_B      = 4'd8;
    localparam logic [3:0] ARI_A_PLUS_B            = 4'd9;
    localparam logic [3:0] ARI_AORNOTB_PLUS_A_AND_B = 4'd10;
    localparam logic [3:0] ARI_A_AND_B_M1          = 4'd11;
    localparam logic [3:0] ARI_A_PLUS_A            = 4'd12;
    localparam logic [3:0] ARI_AORB_PLUS_A         = 4'd13;
    localparam logic [3:0] ARI_AORNOTB_PLUS_A      = 4'd14;
    localparam logic [3:0] ARI_A_M1                = 4'd15;

    typedef struct packed {
        logic cout;
        logic zero;
        logic aeqb;
    } alu_flags_t;

    function automatic alu_flags_t make_flags(input logic carry, input logic all_zero,
                                              input logic all_ones);
        alu_flags_t fl;
        fl.cout = carry;
        fl.zero = all_zero;
        fl.aeqb = all_ones;
        return fl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_74181_core.sv
// ============================================================================
// Module  : alu_74181_core
// Brief   : combinational 74181-style ALU (active-high data, active-high carry)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_74181_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             cin,
    output logic [WIDTH-1:0] F,
    output logic             cout
);
    import alu_74181_pkg::*;

    logic [WIDTH-1:0] logic_f;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ones;

    assign ones = '1;

    always_comb begin
        logic_f = '0;
        case (S)
            LOG_NOT_A:      logic_f = ~A;
            LOG_NOR:        logic_f = ~(A | B);
            LOG_NOTA_AND_B: logic_f = ~A & B;
            LOG_ZERO:       logic_f = '0;
            LOG_NAND:       logic_f = ~(A & B);
            LOG_NOT_B:      logic_f = ~B;
            LOG_XOR:        logic_f = A ^ B;
            LOG_A_AND_NOTB: logic_f = A & ~B;
            LOG_NOTA_OR_B:  logic_f = ~A | B;
            LOG_XNOR:       logic_f = ~(A ^ B);
            LOG_B:          logic_f = B;
            LOG_AND:        logic_f = A & B;
            LOG_ONES:       logic_f = ones;
            LOG_A_OR_NOTB:  logic_f = A | ~B;
            LOG_OR:         logic_f = A | B;
            LOG_A:          logic_f = A;
            default:        logic_f = '0;
        endcase
    end

    // Each arithmetic row is expressed as x + y (+ cin)
    always_comb begin
        x = '0;
        y = '0;
        case (S)
            ARI_A:                    begin x = A;          y = '0;      end
            ARI_A_OR_B:               begin x = A | B;      y = '0;      end
            ARI_A_OR_NOTB:            begin x = A | ~B;     y = '0;      end
            ARI_MINUS1:               begin x = ones;       y = '0;      end
            ARI_A_PLUS_A_ANDNOTB:     begin x = A;          y = A & ~B;  end
            ARI_AORB_PLUS_A_ANDNOTB:  begin x = A | B;      y = A & ~B;  end
            ARI_A_PLUS_NOTB:          begin x = A;          y = ~B;      end
            ARI_A_ANDNOTB_M1:         begin x = A & ~B;     y = ones;    end
            ARI_A_PLUS_A_AND_B:       begin x = A;          y = A & B;   end
            ARI_A_PLUS_B:             begin x = A;          y = B;       end
            ARI_AORNOTB_PLUS_A_AND_B: begin x = A | ~B;     y = A & B;   end
            ARI_A_AND_B_M1:           begin x = A & B;      y = ones;    end
            ARI_A_PLUS_A:             begin x = A;          y = A;       end
            ARI_AORB_PLUS_A:          begin x = A | B;      y = A;       end
            ARI_AORNOTB_PLUS_A:       begin x = A | ~B;     y = A;       end
            ARI_A_M1:                 begin x = A;          y = ones;    end
            default:                  begin x = '0;         y = '0;      end
        endcase
    end

    assign sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign F    = (M == MODE_LOGIC) ? logic_f : sum[WIDTH-1:0];
    assign cout = (M == MODE_ARITH) ? sum[WIDTH] : 1'b0;

endmodule

`default_nettype wire

// File: rtl/alu_74181_pipe.sv
// ============================================================================
// Module  : alu_74181_pipe
// Brief   : two-stage valid/ready pipelined 74181 ALU; ALU_74181_ACC_EN adds
//           an accumulator selectable in place of A via acc_sel
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_74181_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             cin,
`ifdef ALU_74181_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             cout,
    output logic             zero,
    output logic             aeqb
);
    import alu_74181_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        alu_flags_t       flags;
    } result_t;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_s;
    logic             s1_m;
    logic             s1_cin;
    logic             s2_valid;
    result_t          s2_res;
    result_t          res_next;
    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_f;
    logic             core_cout;

    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_load);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_s     <= '0;
            s1_m     <= 1'b0;
            s1_cin   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
                s1_s     <= S;
                s1_m     <= M;
                s1_cin   <= cin;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_74181_ACC_EN
    logic             s1_acc_sel;
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_acc_sel <= 1'b0;
            acc        <= '0;
        end else begin
            if (accept)
                s1_acc_sel <= acc_sel;
            if (s2_load && s1_valid)
                acc <= res_next.f;
        end
    end

    // Accumulator is read at stage-2 load, so a dependent op right behind needs no stall
    assign core_a = s1_acc_sel ? acc : s1_a;
`else
    assign core_a = s1_a;
`endif

    alu_74181_core #(.WIDTH(WIDTH)) u_core (
        .A    (core_a),
        .B    (s1_b),
        .S    (s1_s),
        .M    (s1_m),
        .cin  (s1_cin),
        .F    (core_f),
        .cout (core_cout)
    );

    always_comb begin
        res_next       = '0;
        res_next.f     = core_f;
        res_next.flags = make_flags(core_cout, core_f == '0, &core_f);
    end

    // Data is only refreshed by a real op, so stage 2 never picks up idle-cycle values
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_res <= res_next;
        end
    end

    assign out_valid = s2_valid;
    assign F         = s2_res.f;
    assign cout      = s2_res.flags.cout;
    assign zero      = s2_res.flags.zero;
    assign aeqb      = s2_res.flags.aeqb;

endmodule

`default_nettype wire

// File: tb/tb_alu_74181_pipe.sv
// ============================================================================
// Module  : tb_alu_74181_pipe
// Brief   : directed self-checking bench for alu_74181_pipe (WIDTH=8)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_74181_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] S;
    logic       M;
    logic       cin;
    logic       acc_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] F;
    logic       cout;
    logic       zero;
    logic       aeqb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_74181_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .S         (S),
        .M         (M),
        .cin       (cin),
`ifdef ALU_74181_ACC_EN
        .acc_sel   (acc_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .cout      (cout),
        .zero      (zero),
        .aeqb      (aeqb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge
    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic m, input logic [3:0] s,
                          input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] ef, input logic ec, input logic ez,
                          input logic eq);
        M = m; S = s; A = a; B = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "/in_ready"}, in_ready, 1);
        drive_point();
        in_valid = 1'b0; A = 'x; B = 'x; cin = 1'b0;
        @(negedge clk);
        chk({tag, "/early"}, out_valid, 0);
        drive_point();
        @(negedge clk);
        chk({tag, "/out_valid"}, out_valid, 1);
        chk({tag, "/F"}, F, ef);
        chk({tag, "/cout"}, cout, ec);
        chk({tag, "/zero"}, zero, ez);
        chk({tag, "/aeqb"}, aeqb, eq);
        drive_point();
        @(negedge clk);
        chk({tag, "/no_dup"}, out_valid, 0);
        drive_point();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_sel = 1'b0;
        A = 8'h00; B = 8'h00; S = 4'h0; M = 1'b0; cin = 1'b0;

        // Reset state
        drive_point();
        drive_point();
        @(negedge clk);
        chk("rst/in_ready", in_ready, 0);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/F", F, 8'h00);
        chk("rst/cout", cout, 0);
        chk("rst/zero", zero, 0);
        chk("rst/aeqb", aeqb, 0);
        drive_point();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst/in_ready", in_ready, 1);
        drive_point();

        // Single ops, out_ready held high
        run_op("xor",      1'b1, 4'b0110, 8'h5A, 8'h0F, 1'b0, 8'h55, 0, 0, 0);
        run_op("add",      1'b0, 4'b1001, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 1, 0);
        run_op("add_cin",  1'b0, 4'b1001, 8'hFF, 8'h01, 1'b1, 8'h01, 1, 0, 0);
        run_op("sub_m1",   1'b0, 4'b0110, 8'h3C, 8'h3C, 1'b0, 8'hFF, 0, 0, 1);
        run_op("sub",      1'b0, 4'b0110, 8'h3C, 8'h3C, 1'b1, 8'h00, 1, 1, 0);
        run_op("and",      1'b1, 4'b1011, 8'hF0, 8'h3C, 1'b0, 8'h30, 0, 0, 0);
        run_op("lzero",    1'b1, 4'b0011, 8'hA5, 8'h5A, 1'b1, 8'h00, 0, 1, 0);
        run_op("lones",    1'b1, 4'b1100, 8'h00, 8'h00, 1'b0, 8'hFF, 0, 0, 1);
        run_op("dbl",      1'b0, 4'b1100, 8'h80, 8'h00, 1'b0, 8'h00, 1, 1, 0);
        run_op("la_cin",   1'b1, 4'b1111, 8'h12, 8'h34, 1'b1, 8'h12, 0, 0, 0);
        run_op("minus1",   1'b0, 4'b0011, 8'h12, 8'h34, 1'b0, 8'hFF, 0, 0, 1);
        run_op("a_cin",    1'b0, 4'b0000, 8'hFF, 8'h00, 1'b1, 8'h00, 1, 1, 0);

        // Backpressure: three back-to-back ops, out_ready low for five cycles
        out_ready = 1'b0;
        M = 1'b1; S = 4'b1010; cin = 1'b0; A = 8'h00; B = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        chk("bp/rdy0", in_ready, 1);
        drive_point();
        B = 8'h22;
        @(negedge clk);
        chk("bp/rdy1", in_ready, 1);
        chk("bp/ov1", out_valid, 0);
        drive_point();
        B = 8'h33;
        @(negedge clk);
        chk("bp/rdy2", in_ready, 0);
        chk("bp/ov2", out_valid, 1);
        chk("bp/F2", F, 8'h11);
        drive_point();
        @(negedge clk);
        chk("bp/rdy3", in_ready, 0);
        chk("bp/F3", F, 8'h11);
        drive_point();
        @(negedge clk);
        chk("bp/ov4", out_valid, 1);
        chk("bp/F4", F, 8'h11);
        drive_point();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp/rdy5", in_ready, 1);
        chk("bp/F5", F, 8'h11);
        drive_point();
        in_valid = 1'b0; A = 'x; B = 'x;
        @(negedge clk);
        chk("bp/ov6", out_valid, 1);
        chk("bp/F6", F, 8'h22);
        drive_point();
        @(negedge clk);
        chk("bp/ov7", out_valid, 1);
        chk("bp/F7", F, 8'h33);
        drive_point();
        @(negedge clk);
        chk("bp/drained", out_valid, 0);
        drive_point();

        // Reset with two ops in flight
        M = 1'b1; S = 4'b1111; B = 8'h00; A = 8'hAA; in_valid = 1'b1;
        drive_point();
        A = 8'hBB;
        drive_point();
        in_valid = 1'b0; A = 'x; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst/in_ready", in_ready, 0);
        drive_point();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst/out_valid", out_valid, 0);
        chk("mid_rst/F", F, 8'h00);
        chk("mid_rst/in_ready_after", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            drive_point();
            @(negedge clk);
            chk("mid_rst/no_ghost", out_valid, 0);
        end
        drive_point();

`ifdef ALU_74181_ACC_EN
        // Dependent accumulator chain right after reset
        M = 1'b0; S = 4'b1001; A = 8'h77; B = 8'h01; cin = 1'b0; acc_sel = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        drive_point();
        @(negedge clk);
        drive_point();
        @(negedge clk);
        chk("acc/F1", F, 8'h01);
        drive_point();
        in_valid = 1'b0; acc_sel = 1'b0;
        @(negedge clk);
        chk("acc/F2", F, 8'h02);
        drive_point();
        @(negedge clk);
        chk("acc/F3", F, 8'h03);
        drive_point();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
